// File: rtl/flexsoc_rst_seq.sv
// rtl/flexsoc_rst_seq.sv - PLL-qualified power-on/system reset sequencer with sticky cause register
module flexsoc_rst_seq #(
    parameter int LOCK_FILTER  = 4,
    parameter int POR_CYCLES   = 16,
    parameter int SYS_CYCLES   = 8,
    parameter int LOCKUP_RESET = 1
) (
    input  logic       hclk,
    input  logic       RESET,
    input  logic       hpll_locked,
    input  logic       tpll_locked,
    input  logic       sysresetreq,
    input  logic       host_rst_req,
    input  logic       lockup,
    input  logic       cause_clr,
    output logic       poreset_n,
    output logic       hreset_n,
    output logic [4:0] rst_cause,
    output logic [1:0] rst_state
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        POR_HOLD  = 2'd1,
        SYS_HOLD  = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_FILTER);
    localparam logic [7:0] POR_LOAD = 8'(POR_CYCLES - 1);
    localparam logic [7:0] SYS_LOAD = 8'(SYS_CYCLES - 1);
    localparam logic       LOCKUP_EN = (LOCKUP_RESET != 0);

    logic [1:0] hsync_q;
    logic [1:0] tsync_q;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    state_t     state_q, state_d;
    logic [4:0] cause_q, cause_d, cause_set;
    logic       poreset_n_q, hreset_n_q;
    logic       lock_ok;
    logic [2:0] req_vec;
    logic       sys_req;

    always_comb begin
        lock_ok    = hsync_q[1] & tsync_q[1];
        req_vec    = {lockup & LOCKUP_EN, host_rst_req, sysresetreq};
        sys_req    = |req_vec;
        lock_cnt_d = '0;
        if (lock_ok) begin
            lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 4'd1;
        end
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cause_set  = '0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_cnt_d == LOCK_MAX) begin
                    state_d    = POR_HOLD;
                    hold_cnt_d = POR_LOAD;
                end
            end
            POR_HOLD: begin
                if (hold_cnt_q == 8'd0) begin
                    state_d    = SYS_HOLD;
                    hold_cnt_d = SYS_LOAD;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            SYS_HOLD: begin
                // A request that is still active keeps the core held and re-records its source.
                if (sys_req) begin
                    hold_cnt_d     = SYS_LOAD;
                    cause_set[4:2] = req_vec;
                end else if (hold_cnt_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            RUN: begin
                if (sys_req) begin
                    state_d        = SYS_HOLD;
                    hold_cnt_d     = SYS_LOAD;
                    cause_set[4:2] = req_vec;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        // Lock loss overrides whatever the state logic above decided.
        if (!lock_ok && state_q != WAIT_LOCK) begin
            state_d    = WAIT_LOCK;
            hold_cnt_d = '0;
            cause_set  = 5'b00010;
        end
        cause_d = (cause_clr ? 5'b00000 : cause_q) | cause_set;
    end

    always_ff @(posedge hclk) begin
        if (RESET) begin
            hsync_q     <= '0;
            tsync_q     <= '0;
            lock_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            state_q     <= WAIT_LOCK;
            cause_q     <= 5'b00001;
            poreset_n_q <= 1'b0;
            hreset_n_q  <= 1'b0;
        end else begin
            hsync_q     <= {hsync_q[0], hpll_locked};
            tsync_q     <= {tsync_q[0], tpll_locked};
            lock_cnt_q  <= lock_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            state_q     <= state_d;
            cause_q     <= cause_d;
            poreset_n_q <= (state_d == SYS_HOLD) || (state_d == RUN);
            hreset_n_q  <= (state_d == RUN);
        end
    end

    assign poreset_n = poreset_n_q;
    assign hreset_n  = hreset_n_q;
    assign rst_cause = cause_q;
    assign rst_state = state_q;

endmodule

// File: doc/flexsoc_rst_seq.md
# flexsoc_rst_seq

Reset sequencer for the flexsoc_cm3 FPGA top level. It replaces the free-running reset counter with a state machine that qualifies both PLL lock signals and releases power-on reset (debug plus system) and system reset (core/bus only) in a fixed order. It also converts core SYSRESETREQ, host-requested resets and optional core LOCKUP into system-only resets, and keeps a sticky reset-cause register readable over the host transport.

## Interface
Parameters:
- LOCK_FILTER, 4: consecutive synchronized cycles both PLLs must be locked before the sequence proceeds (1..15).
- POR_CYCLES, 16: cycles poreset_n is held low after lock qualification (1..255).
- SYS_CYCLES, 8: cycles hreset_n is held low after poreset_n release or after a system-reset request (1..255).
- LOCKUP_RESET, 1: 1 means core LOCKUP causes a system reset; 0 means LOCKUP is ignored.

Ports:
- hclk  in  1  system clock.
- RESET  in  1  synchronous, active-high reset; board pushbutton, already synchronized to hclk.
- hpll_locked  in  1  HCLK PLL lock; asynchronous, synchronized internally.
- tpll_locked  in  1  transport PLL lock; asynchronous, synchronized internally.
- sysresetreq  in  1  core system reset request, hclk domain, level.
- host_rst_req  in  1  host/transport reset request, hclk domain, level or pulse.
- lockup  in  1  core lockup, hclk domain, level.
- cause_clr  in  1  one-cycle pulse that clears rst_cause.
- poreset_n  out  1  power-on reset to the SoC, active-low, registered.
- hreset_n  out  1  system reset to the core and bus, active-low, registered.
- rst_cause  out  5  sticky causes: [0] pin/POR, [1] PLL lock loss, [2] SYSRESETREQ, [3] host request, [4] lockup.
- rst_state  out  2  current state, for debug.

## Operation
- Synchronizer: two flops per lock input, cleared by RESET. lock_ok = both synchronized locks high.
- lock_cnt counts consecutive lock_ok cycles and saturates at LOCK_FILTER. It clears whenever lock_ok is low.
- States and rst_state encoding:
  - WAIT_LOCK=0: poreset_n=0, hreset_n=0. Moves to POR_HOLD on the edge where lock_cnt reaches LOCK_FILTER.
  - POR_HOLD=1: poreset_n=0, hreset_n=0. Occupied for exactly POR_CYCLES cycles, then moves to SYS_HOLD. poreset_n rises on entry to SYS_HOLD.
  - SYS_HOLD=2: poreset_n=1, hreset_n=0. Occupied for at least SYS_CYCLES cycles. Exits to RUN only when the count is done and no system request is active. Any active request restarts the count.
  - RUN=3: poreset_n=1, hreset_n=1.
- System request = sysresetreq | host_rst_req | (lockup & LOCKUP_RESET).
  - In RUN, a system request moves the FSM to SYS_HOLD.
  - In WAIT_LOCK and POR_HOLD, requests are ignored and not recorded.
- Lock loss: lock_ok low in POR_HOLD, SYS_HOLD or RUN forces WAIT_LOCK and sets cause[1]. Counters clear. Lock loss has priority over any simultaneous request.
- Cause bits are set on the edge where the triggering transition is taken. In SYS_HOLD, an active request also re-sets its own bit.
- cause_clr clears all bits. If a set and cause_clr occur in the same cycle, the set wins for that bit.
- Hold counters are 8 bits and never wrap; each reloads on state entry.

## Timing
- RESET high at an edge: state=WAIT_LOCK, poreset_n=0, hreset_n=0, rst_cause=5'b00001, rst_state=0, sync flops=0, counters=0. This holds for RESET asserted mid-sequence or in RUN.
- With both locks steady high and defaults, count from the first edge with RESET low (edge 1):
  - poreset_n rises after edge 2+LOCK_FILTER+POR_CYCLES = edge 22.
  - hreset_n rises SYS_CYCLES later, after edge 30.
- Request in RUN at edge k: hreset_n low after edge k+1 and high again after edge k+1+SYS_CYCLES if the request is gone. poreset_n stays high.
- Lock drop: both outputs go low 3 edges after the raw lock input falls (2 sync flops plus state register).
- All outputs are registered and glitch-free. Combinational paths from inputs to outputs are forbidden.

## Test plan
- Power-up: RESET high 5 cycles, both locks high. Expect poreset_n rising after edge 22, hreset_n after edge 30, rst_cause=00001, rst_state sequence 0→1→2→3.
- Lock bounce: hpll_locked toggles high 3 cycles, low 1 cycle, repeatedly. Expect the FSM never leaves WAIT_LOCK. Then hold it high: expect the normal 22/30 release.
- SYSRESETREQ: 1-cycle pulse in RUN. Expect hreset_n low for exactly 8 cycles, poreset_n constant 1, cause=00101. Then cause_clr: expect 00000.
- Held request: host_rst_req high 20 cycles in RUN. Expect hreset_n low until 8 cycles after the request drops, and cause[3]=1.
- Lock loss in SYS_HOLD: tpll_locked falls. Expect both resets low, cause[1]=1, state 0, and the full sequence repeating on relock. lockup with LOCKUP_RESET=0: no reset and cause unchanged.
- Simultaneous events: cause_clr in the same cycle as a sysresetreq-triggered transition. Expect cause=00100. RESET asserted in RUN: both outputs low next edge and cause=00001.
